// File: rtl/givens_rotation_scheduler_if.sv
// Issue/retire channel between the Givens rotation scheduler and the shared
// CORDIC rotation engine.
//   master (scheduler): drives issueValid, issueRow, issueCol, issueDisable,
//                       issueSign; samples issueReady, retireValid.
//   slave  (engine)   : the reverse directions.
// Parameters: matrixSize (N), addrWidth (row/column index width).
interface givens_rotation_scheduler_if #(
  parameter int matrixSize = 4,
  parameter int addrWidth  = $clog2(matrixSize)
);
  logic                  issueValid;
  logic                  issueReady;
  logic [addrWidth-1:0]  issueRow;
  logic [addrWidth-1:0]  issueCol;
  logic [matrixSize-1:0] issueDisable;
  logic [matrixSize-1:0] issueSign;
  logic                  retireValid;

  modport master (
    output issueValid, issueRow, issueCol, issueDisable, issueSign,
    input  issueReady, retireValid
  );

  modport slave (
    input  issueValid, issueRow, issueCol, issueDisable, issueSign,
    output issueReady, retireValid
  );
endinterface

// File: rtl/givens_rotation_scheduler.sv
// Givens rotation scheduler: steps a shared CORDIC rotation engine through one
// QR triangularisation sweep of an N x N matrix, issuing (pivot row r, target
// row c) pairs in column-major order with their core-disable and
// sign-dictator masks. One pair is outstanding at a time; the scheduler
// advances only after the engine's write-back retire.
//
// Ports:
//   clk, nRst      clock; synchronous active-low reset
//   start          begin a sweep (sampled in IDLE only)
//   abort          synchronous abort, highest priority; back to IDLE, no done
//   busy           high whenever not IDLE
//   done           one-cycle pulse at sweep end (normal or watchdog)
//   issue          engine channel (master modport of givens_rotation_scheduler_if)
//   pairIndex      retired-pair count for the current/last sweep
//   errTimeout     sticky watchdog flag, cleared by the next accepted start
//
// Build option: define QR_SCHED_TIMEOUT_EN to include the WAIT watchdog
// (timeoutCycles / timeoutWidth). Without it WAIT holds indefinitely and
// errTimeout is tied low.
module givens_rotation_scheduler #(
  parameter int matrixSize    = 4,
  parameter int addrWidth     = $clog2(matrixSize),
  parameter int timeoutCycles = 255,
  parameter int timeoutWidth  = 8
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  givens_rotation_scheduler_if.master issue,
  output logic [addrWidth*2-1:0]     pairIndex,
  output logic                       errTimeout
);

  localparam int PW = addrWidth * 2;
  localparam logic [addrWidth-1:0] LAST_COL   = addrWidth'(matrixSize - 1);
  localparam logic [addrWidth-1:0] LAST_PIVOT = addrWidth'(matrixSize - 2);

  if (matrixSize < 2) begin : g_bad_size
    $error("givens_rotation_scheduler: matrixSize must be at least 2");
  end
  if (timeoutCycles < 1 || timeoutCycles > (1 << timeoutWidth) - 1) begin : g_bad_timeout
    $error("givens_rotation_scheduler: timeoutCycles must fit in timeoutWidth bits");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, DONE} state_t;
  state_t state, state_next;

  logic more_cols;
  logic more_rows;
  logic timeout_fire;

  assign more_cols = issue.issueCol < LAST_COL;
  assign more_rows = issue.issueRow < LAST_PIVOT;

`ifdef QR_SCHED_TIMEOUT_EN
  localparam logic [timeoutWidth-1:0] WDOG_LAST = timeoutWidth'(timeoutCycles - 1);
  localparam logic [timeoutWidth-1:0] WDOG_SAT  = '1;
  logic [timeoutWidth-1:0] wdog;

  // wdog holds the number of WAIT cycles already elapsed; the cycle on which
  // it equals timeoutCycles-1 is the timeoutCycles-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      wdog <= '0;
    end else if (state == ISSUE && issue.issueReady) begin
      wdog <= '0;
    end else if (state == WAIT && wdog != WDOG_SAT) begin
      wdog <= wdog + timeoutWidth'(1);
    end
  end

  assign timeout_fire = (state == WAIT) && !issue.retireValid && (wdog == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      errTimeout <= 1'b0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        errTimeout <= 1'b0;
      end else if (timeout_fire) begin
        errTimeout <= 1'b1;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign errTimeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (issue.issueReady) state_next = WAIT;
      WAIT: begin
        if (issue.retireValid) state_next = ADVANCE;
        else if (timeout_fire) state_next = DONE;
      end
      ADVANCE: state_next = (more_cols || more_rows) ? ISSUE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Status outputs are registered from the next state so they line up with
  // the state register rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      issue.issueValid <= 1'b0;
    end else begin
      busy             <= (state_next != IDLE);
      done             <= (state_next == DONE);
      issue.issueValid <= (state_next == ISSUE);
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      issue.issueRow     <= '0;
      issue.issueCol     <= addrWidth'(1);
      issue.issueDisable <= '0;
      issue.issueSign    <= matrixSize'(1);
      pairIndex          <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            issue.issueRow     <= '0;
            issue.issueCol     <= addrWidth'(1);
            issue.issueDisable <= '0;
            issue.issueSign    <= matrixSize'(1);
            pairIndex          <= '0;
          end
        end
        WAIT: begin
          if (issue.retireValid) pairIndex <= pairIndex + PW'(1);
        end
        ADVANCE: begin
          if (more_cols) begin
            issue.issueCol <= issue.issueCol + addrWidth'(1);
          end else if (more_rows) begin
            // New pivot r+1 starts at target column r+2; one more leading
            // core is disabled and the sign dictator moves to the new pivot.
            issue.issueRow     <= issue.issueRow + addrWidth'(1);
            issue.issueCol     <= issue.issueRow + addrWidth'(1) + addrWidth'(1);
            issue.issueDisable <= {issue.issueDisable[matrixSize-2:0], 1'b1};
            issue.issueSign    <= {issue.issueSign[matrixSize-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
